// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and register file.
// Holds the default data and address widths, the bit positions inside the
// 2-bit WB control field, and the index of the hardwired-zero register.
package wb_regfile_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;

  // Bit positions inside the WB control field coming from MEM/WB.
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_if.sv
// Bundle of MEM/WB write-back signals, decode-stage read ports and debug outputs.
//   WB      : write-back control, WB[1]=RegWrite, WB[0]=MemToReg
//   RData   : memory read data
//   ALU     : ALU result
//   Mux5    : destination register index
//   RA1/RA2 : read addresses
//   RD1/RD2 : read data
//   WBData  : selected write-back value (to forwarding unit)
//   WBCount : number of committed register writes
// The master modport is the pipeline side; the slave modport is the register file.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
);

  logic [1:0]    WB;
  logic [DW-1:0] RData;
  logic [DW-1:0] ALU;
  logic [AW-1:0] Mux5;
  logic [AW-1:0] RA1;
  logic [AW-1:0] RA2;
  logic [DW-1:0] RD1;
  logic [DW-1:0] RD2;
  logic [DW-1:0] WBData;
  logic [31:0]   WBCount;

  modport master (
    output WB, RData, ALU, Mux5, RA1, RA2,
    input  RD1, RD2, WBData, WBCount
  );

  modport slave (
    input  WB, RData, ALU, Mux5, RA1, RA2,
    output RD1, RD2, WBData, WBCount
  );

endinterface

// File: rtl/wb_mux.sv
// 2:1 MemToReg selector producing the write-back value.
// Shared between the register-file write path and the forwarding path.
//   mem_to_reg_i : 1 selects rdata_i, 0 selects alu_i
//   rdata_i      : memory read data
//   alu_i        : ALU result
//   wb_data_o    : selected write-back value
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          mem_to_reg_i,
  input  logic [DW-1:0] rdata_i,
  input  logic [DW-1:0] alu_i,
  output logic [DW-1:0] wb_data_o
);

  always_comb begin
    wb_data_o = alu_i;
    if (mem_to_reg_i) begin
      wb_data_o = rdata_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 32 x 32-bit architectural register file.
// Selects the write-back value, commits it on the rising clock edge, serves two
// combinational read ports and counts committed writes.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears registers and WBCount
//   bus : wb_regfile_if slave modport (MEM/WB inputs, read ports, WBData, WBCount)
// Build option: define WB_BYPASS_EN for a write-first register file, where a read
// of the register being written this cycle returns WBData instead of the old value.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input logic        clk,
  input logic        rst,
  wb_regfile_if.slave bus
);

  localparam int unsigned NumRegs = 1 << AW;

  logic [DW-1:0] wb_data;
  logic          we;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  logic [DW-1:0] regs_q [NumRegs];
  logic [DW-1:0] regs_d [NumRegs];
  logic [31:0]   count_q;
  logic [31:0]   count_d;

  wb_mux #(
    .DW(DW)
  ) u_wb_mux (
    .mem_to_reg_i(bus.WB[WB_MEMTOREG]),
    .rdata_i     (bus.RData),
    .alu_i       (bus.ALU),
    .wb_data_o   (wb_data)
  );

  // Writes to register 0 are dropped here so they never reach the counter either.
  assign we = bus.WB[WB_REGWRITE] && (bus.Mux5 != AW'(REG_ZERO));

  always_comb begin
    for (int i = 0; i < int'(NumRegs); i++) begin
      regs_d[i] = regs_q[i];
    end
    count_d = count_q;
    if (we) begin
      regs_d[bus.Mux5] = wb_data;
      count_d          = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= regs_d[i];
      end
      count_q <= count_d;
    end
  end

  // Reads are gated by rst so the bypass cannot leak WBData while in reset.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!rst) begin
      if (bus.RA1 != AW'(REG_ZERO)) begin
        rd1 = regs_q[bus.RA1];
`ifdef WB_BYPASS_EN
        if (we && (bus.RA1 == bus.Mux5)) begin
          rd1 = wb_data;
        end
`endif
      end
      if (bus.RA2 != AW'(REG_ZERO)) begin
        rd2 = regs_q[bus.RA2];
`ifdef WB_BYPASS_EN
        if (we && (bus.RA2 == bus.Mux5)) begin
          rd2 = wb_data;
        end
`endif
      end
    end
  end

  assign bus.RD1     = rd1;
  assign bus.RD2     = rd2;
  assign bus.WBData  = wb_data;
  assign bus.WBCount = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  wb_regfile_if #(.DW(32), .AW(5)) bus ();

  wb_regfile #(
    .DW(32),
    .AW(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_bypass;
    total = 0;
    bad   = 0;

    rst       = 1'b1;
    bus.WB    = 2'b00;
    bus.RData = '0;
    bus.ALU   = '0;
    bus.Mux5  = '0;
    bus.RA1   = 5'd5;
    bus.RA2   = 5'd0;
    #1;
    check("rst_rd1", bus.RD1, 32'h0);
    check("rst_cnt", bus.WBCount, 32'h0);

    // WBData follows its inputs during reset.
    bus.WB    = 2'b01;
    bus.RData = 32'h0000_00A5;
    bus.ALU   = 32'h0000_005A;
    #1;
    check("rst_wbdata_mem", bus.WBData, 32'h0000_00A5);
    bus.WB = 2'b00;
    #1;
    check("rst_wbdata_alu", bus.WBData, 32'h0000_005A);

    // A write on an edge while rst is high is discarded.
    bus.WB   = 2'b10;
    bus.Mux5 = 5'd5;
    bus.ALU  = 32'h0000_0099;
    @(posedge clk);
    #1;
    check("rst_wr_cnt", bus.WBCount, 32'h0);
    check("rst_wr_rd1", bus.RD1, 32'h0);

    // First write after deassert lands on the next edge.
    @(negedge clk);
    rst     = 1'b0;
    bus.ALU = 32'h0000_1234;
    #1;
    check("post_rst_rd1_old", bus.RD1 & 32'hFFFF_0000, 32'h0);
    @(posedge clk);
    #1;
    check("wr5_rd1", bus.RD1, 32'h0000_1234);
    check("wr5_cnt", bus.WBCount, 32'd1);

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    bus.WB = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    check("pulse_rd1", bus.RD1, 32'h0);
    check("pulse_cnt", bus.WBCount, 32'h0);
    #1;
    rst = 1'b0;
    #0.5;
    check("pulse_rel_rd1", bus.RD1, 32'h0);

    // ALU write-back to r7.
    @(negedge clk);
    bus.WB    = 2'b10;
    bus.ALU   = 32'hDEAD_BEEF;
    bus.RData = 32'h0000_0001;
    bus.Mux5  = 5'd7;
    bus.RA1   = 5'd7;
    #1;
    check("t2_wbdata", bus.WBData, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    check("t2_rd1", bus.RD1, 32'hDEAD_BEEF);
    check("t2_cnt", bus.WBCount, 32'd1);

    // Memory write-back to r31, read on both ports.
    @(negedge clk);
    bus.WB    = 2'b11;
    bus.RData = 32'hCAFE_F00D;
    bus.ALU   = 32'h0;
    bus.Mux5  = 5'd31;
    bus.RA1   = 5'd31;
    bus.RA2   = 5'd31;
    #1;
    check("t3_wbdata", bus.WBData, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    check("t3_rd2", bus.RD2, 32'hCAFE_F00D);
    check("t3_rd1_same", bus.RD1, 32'hCAFE_F00D);
    check("t3_cnt", bus.WBCount, 32'd2);

    // Write attempt to r0.
    @(negedge clk);
    bus.WB   = 2'b10;
    bus.Mux5 = 5'd0;
    bus.ALU  = 32'hFFFF_FFFF;
    bus.RA1  = 5'd0;
    #1;
    check("t4_rd1_pre", bus.RD1, 32'h0);
    @(posedge clk);
    #1;
    check("t4_rd1", bus.RD1, 32'h0);
    check("t4_cnt", bus.WBCount, 32'd2);
    check("t4_r31_kept", bus.RD2, 32'hCAFE_F00D);

    // Store r3=0x11, then same-cycle read of r3 while writing 0x22.
    @(negedge clk);
    bus.WB   = 2'b10;
    bus.Mux5 = 5'd3;
    bus.ALU  = 32'h0000_0011;
    bus.RA1  = 5'd3;
    bus.RA2  = 5'd4;
    @(posedge clk);
    #1;
    check("t5_r3_init", bus.RD1, 32'h0000_0011);
    check("t5_cnt_a", bus.WBCount, 32'd3);
    @(negedge clk);
    bus.ALU = 32'h0000_0022;
    #1;
`ifdef WB_BYPASS_EN
    exp_bypass = 32'h0000_0022;
`else
    exp_bypass = 32'h0000_0011;
`endif
    check("t5_same_cycle", bus.RD1, exp_bypass);
    check("t5_rd2_other", bus.RD2, 32'h0);
    @(posedge clk);
    #1;
    check("t5_rd1_after", bus.RD1, 32'h0000_0022);
    check("t5_cnt_b", bus.WBCount, 32'd4);

    // RegWrite low for 10 cycles.
    @(negedge clk);
    bus.WB   = 2'b00;
    bus.Mux5 = 5'd4;
    bus.ALU  = 32'h0000_0055;
    bus.RA1  = 5'd4;
    repeat (10) @(posedge clk);
    #1;
    check("t6_r4", bus.RD1, 32'h0);
    check("t6_cnt", bus.WBCount, 32'd4);

    // Back-to-back writes on consecutive edges.
    @(negedge clk);
    bus.WB   = 2'b10;
    bus.Mux5 = 5'd8;
    bus.ALU  = 32'h0000_0080;
    @(negedge clk);
    bus.Mux5 = 5'd9;
    bus.ALU  = 32'h0000_0090;
    @(negedge clk);
    bus.WB  = 2'b00;
    bus.RA1 = 5'd8;
    bus.RA2 = 5'd9;
    #1;
    check("b2b_r8", bus.RD1, 32'h0000_0080);
    check("b2b_r9", bus.RD2, 32'h0000_0090);
    check("b2b_cnt", bus.WBCount, 32'd6);

    // Reset clears everything immediately.
    rst     = 1'b1;
    bus.RA1 = 5'd7;
    #1;
    check("final_rst_rd1", bus.RD1, 32'h0);
    check("final_rst_rd2", bus.RD2, 32'h0);
    check("final_rst_cnt", bus.WBCount, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
